// File: rtl/aud_gain_stage.sv
// Two-channel digital gain stage between the codec ADC and DAC ports: ramped
// per-channel gain with mute, one shared multiplier, saturation and DAC hand-off.
module aud_gain_stage #(
   parameter int unsigned RAMP_SAMPLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init_done,
   input  logic [1:0]  aud_dout_vld,
   input  logic [23:0] aud_dout,
   input  logic [1:0]  aud_din_ack,
   output logic [23:0] aud_din0,
   output logic [23:0] aud_din1,
   input  logic [7:0]  gain_tgt0,
   input  logic [7:0]  gain_tgt1,
   input  logic        mute,
   output logic [7:0]  gain_cur0,
   output logic [7:0]  gain_cur1,
   output logic [1:0]  din_fresh,
   output logic [7:0]  underrun_cnt,
   input  logic        underrun_clr
);
   localparam logic [7:0] RAMP_LAST = 8'(RAMP_SAMPLES - 32'd1);

   logic [1:0]  vld_s, ack_s, wr_s, und_ev_s;
   logic        slot_vld_q, slot_vld_d, slot_ch_q, slot_ch_d;
   logic [23:0] slot_smp_q, slot_smp_d;
   logic [7:0]  slot_gain_q, slot_gain_d;
   logic        pend_vld_q, pend_vld_d;
   logic [23:0] pend_smp_q, pend_smp_d;
   logic [7:0]  pend_gain_q, pend_gain_d;
   logic        prod_vld_q, prod_vld_d, prod_ch_q, prod_ch_d;
   logic [32:0] prod_q, prod_d;
   logic [23:0] sat_s;
   logic [23:0] din0_q, din0_d, din1_q, din1_d;
   logic [1:0]  fresh_q, fresh_d;
   logic [7:0]  und_q, und_d;
   logic [8:0]  und_sum_s;
   logic [7:0]  ramp_q, ramp_d, gcur0_q, gcur0_d, gcur1_q, gcur1_d;

   // Product >>> 6 is 27 bits; clamp to the 24-bit signed range.
   function automatic logic [23:0] sat24(input logic [26:0] v);
      if ((v[26:23] == 4'b0000) || (v[26:23] == 4'b1111)) begin
         sat24 = v[23:0];
      end else if (v[26]) begin
         sat24 = 24'h800000;
      end else begin
         sat24 = 24'h7FFFFF;
      end
   endfunction

   function automatic logic [7:0] step_gain(input logic [7:0] cur, input logic [7:0] tgt);
      if (cur < tgt) begin
         step_gain = cur + 8'd1;
      end else if (cur > tgt) begin
         step_gain = cur - 8'd1;
      end else begin
         step_gain = cur;
      end
   endfunction

   // Input arbitration: channel 0 wins a tie, channel 1 waits one cycle in the pending slot.
   always_comb begin
      vld_s       = init_done ? aud_dout_vld : 2'b00;
      slot_vld_d  = 1'b0;
      slot_ch_d   = 1'b0;
      slot_smp_d  = slot_smp_q;
      slot_gain_d = slot_gain_q;
      pend_vld_d  = pend_vld_q;
      pend_smp_d  = pend_smp_q;
      pend_gain_d = pend_gain_q;
      if (vld_s[0]) begin
         slot_vld_d  = 1'b1;
         slot_smp_d  = aud_dout;
         slot_gain_d = gcur0_q;
         if (vld_s[1]) begin
            pend_vld_d  = 1'b1;
            pend_smp_d  = aud_dout;
            pend_gain_d = gcur1_q;
         end else begin
            pend_vld_d  = pend_vld_q;
         end
      end else if (vld_s[1]) begin
         slot_vld_d  = 1'b1;
         slot_ch_d   = 1'b1;
         slot_smp_d  = aud_dout;
         slot_gain_d = gcur1_q;
         pend_vld_d  = 1'b0;
      end else if (pend_vld_q) begin
         slot_vld_d  = 1'b1;
         slot_ch_d   = 1'b1;
         slot_smp_d  = pend_smp_q;
         slot_gain_d = pend_gain_q;
         pend_vld_d  = 1'b0;
      end else begin
         slot_vld_d  = 1'b0;
      end
      if (!init_done) begin
         slot_vld_d = 1'b0;
         pend_vld_d = 1'b0;
      end else begin
         pend_vld_d = pend_vld_d;
      end
   end

   // Shared multiplier, stage-2 saturation and the DAC handshake / underrun counter.
   always_comb begin
      ack_s      = init_done ? aud_din_ack : 2'b00;
      prod_vld_d = slot_vld_q & init_done;
      prod_ch_d  = slot_ch_q;
      prod_d     = {{9{slot_smp_q[23]}}, slot_smp_q} * {25'd0, slot_gain_q};
      sat_s      = sat24(prod_q[32:6]);
      wr_s[0]    = prod_vld_q & init_done & ~prod_ch_q;
      wr_s[1]    = prod_vld_q & init_done & prod_ch_q;
      und_ev_s   = ack_s & ~fresh_q & ~wr_s;
      din0_d     = din0_q;
      din1_d     = din1_q;
      fresh_d    = fresh_q & ~ack_s;
      if (!init_done) begin
         din0_d  = 24'd0;
         din1_d  = 24'd0;
         fresh_d = 2'b00;
      end else begin
         if (wr_s[0]) begin
            din0_d     = sat_s;
            fresh_d[0] = 1'b1;
         end else begin
            din0_d     = din0_q;
         end
         if (wr_s[1]) begin
            din1_d     = sat_s;
            fresh_d[1] = 1'b1;
         end else begin
            din1_d     = din1_q;
         end
      end
      und_sum_s = {1'b0, und_q} + {8'd0, und_ev_s[0]} + {8'd0, und_ev_s[1]};
      if (underrun_clr) begin
         und_d = 8'd0;
      end else if (und_sum_s > 9'd255) begin
         und_d = 8'hFF;
      end else begin
         und_d = und_sum_s[7:0];
      end
   end

   // Gain ramp: one step toward the effective target every RAMP_SAMPLES channel-0 strobes.
   always_comb begin
      ramp_d  = ramp_q;
      gcur0_d = gcur0_q;
      gcur1_d = gcur1_q;
      if (vld_s[0]) begin
         if (ramp_q == RAMP_LAST) begin
            ramp_d  = 8'd0;
            gcur0_d = step_gain(gcur0_q, mute ? 8'd0 : gain_tgt0);
            gcur1_d = step_gain(gcur1_q, mute ? 8'd0 : gain_tgt1);
         end else begin
            ramp_d  = ramp_q + 8'd1;
         end
      end else begin
         ramp_d = ramp_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_vld_q  <= 1'b0;
         slot_ch_q   <= 1'b0;
         slot_smp_q  <= 24'd0;
         slot_gain_q <= 8'd0;
         pend_vld_q  <= 1'b0;
         pend_smp_q  <= 24'd0;
         pend_gain_q <= 8'd0;
         prod_vld_q  <= 1'b0;
         prod_ch_q   <= 1'b0;
         prod_q      <= 33'd0;
         din0_q      <= 24'd0;
         din1_q      <= 24'd0;
         fresh_q     <= 2'b00;
         und_q       <= 8'd0;
         ramp_q      <= 8'd0;
         gcur0_q     <= 8'd0;
         gcur1_q     <= 8'd0;
      end else begin
         slot_vld_q  <= slot_vld_d;
         slot_ch_q   <= slot_ch_d;
         slot_smp_q  <= slot_smp_d;
         slot_gain_q <= slot_gain_d;
         pend_vld_q  <= pend_vld_d;
         pend_smp_q  <= pend_smp_d;
         pend_gain_q <= pend_gain_d;
         prod_vld_q  <= prod_vld_d;
         prod_ch_q   <= prod_ch_d;
         prod_q      <= prod_d;
         din0_q      <= din0_d;
         din1_q      <= din1_d;
         fresh_q     <= fresh_d;
         und_q       <= und_d;
         ramp_q      <= ramp_d;
         gcur0_q     <= gcur0_d;
         gcur1_q     <= gcur1_d;
      end
   end

   assign aud_din0     = din0_q;
   assign aud_din1     = din1_q;
   assign din_fresh    = fresh_q;
   assign gain_cur0    = gcur0_q;
   assign gain_cur1    = gcur1_q;
   assign underrun_cnt = und_q;

endmodule

// File: tb/tb_aud_gain_stage.sv
// Randomised bench for aud_gain_stage: a cycle-level behavioural model built
// from arithmetic and a due-time schedule, plus hand-computed literal checks.
module tb_aud_gain_stage;
   localparam int R = 2;

   logic        clk = 1'b0;
   logic        rst, init_done, mute, underrun_clr;
   logic [1:0]  aud_dout_vld, aud_din_ack, din_fresh;
   logic [23:0] aud_dout, aud_din0, aud_din1;
   logic [7:0]  gain_tgt0, gain_tgt1, gain_cur0, gain_cur1, underrun_cnt;

   always #5 clk = ~clk;

   aud_gain_stage #(.RAMP_SAMPLES(R)) dut (
      .clk(clk), .rst(rst), .init_done(init_done),
      .aud_dout_vld(aud_dout_vld), .aud_dout(aud_dout), .aud_din_ack(aud_din_ack),
      .aud_din0(aud_din0), .aud_din1(aud_din1),
      .gain_tgt0(gain_tgt0), .gain_tgt1(gain_tgt1), .mute(mute),
      .gain_cur0(gain_cur0), .gain_cur1(gain_cur1), .din_fresh(din_fresh),
      .underrun_cnt(underrun_cnt), .underrun_clr(underrun_clr)
   );

   int n_vec = 0;
   int n_bad = 0;

   logic [23:0] m_din [2];
   bit          m_fresh [2];
   int          m_gain [2];
   int          m_und, m_ramp, cyc;
   bit          p_ok;
   logic [23:0] p_smp;
   int          p_gain;
   bit          d_ok [2][4];
   logic [23:0] d_val [2][4];

   // floor(sample * gain / 64), clamped to 24-bit signed
   function automatic logic [23:0] ref_val(input logic [23:0] smp, input int g);
      longint p, q;
      p = longint'($signed(smp)) * longint'(g);
      q = p / 64;
      if ((p % 64 != 0) && (p < 0)) q = q - 1;
      if (q > 8388607) q = 8388607;
      if (q < -8388608) q = -8388608;
      return q[23:0];
   endfunction

   function automatic int toward(input int cur, input int tgt);
      if (cur < tgt) return cur + 1;
      if (cur > tgt) return cur - 1;
      return cur;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_din[c] = 24'd0; m_fresh[c] = 1'b0; m_gain[c] = 0;
         for (int k = 0; k < 4; k++) d_ok[c][k] = 1'b0;
      end
      m_und = 0; m_ramp = 0; p_ok = 1'b0;
   endtask

   task automatic sched(input int ch, input logic [23:0] s, input int g);
      d_ok[ch][(cyc + 2) % 4]  = 1'b1;
      d_val[ch][(cyc + 2) % 4] = ref_val(s, g);
   endtask

   // Advances the model across the coming rising edge using the current inputs.
   task automatic model_step();
      bit          w [2];
      logic [23:0] wv [2];
      int          ev;
      if (rst) begin
         model_reset();
      end else begin
         for (int c = 0; c < 2; c++) begin
            w[c] = d_ok[c][cyc % 4];
            wv[c] = d_val[c][cyc % 4];
            d_ok[c][cyc % 4] = 1'b0;
         end
         if (!init_done) begin
            for (int c = 0; c < 2; c++) begin
               m_din[c] = 24'd0; m_fresh[c] = 1'b0;
               for (int k = 0; k < 4; k++) d_ok[c][k] = 1'b0;
            end
            p_ok = 1'b0;
         end else begin
            ev = 0;
            for (int c = 0; c < 2; c++) begin
               if (w[c]) begin
                  m_din[c] = wv[c]; m_fresh[c] = 1'b1;
               end else if (aud_din_ack[c]) begin
                  if (m_fresh[c]) m_fresh[c] = 1'b0;
                  else ev++;
               end
            end
            m_und = (m_und + ev > 255) ? 255 : m_und + ev;
            if (aud_dout_vld[0]) begin
               sched(0, aud_dout, m_gain[0]);
               if (aud_dout_vld[1]) begin
                  p_ok = 1'b1; p_smp = aud_dout; p_gain = m_gain[1];
               end
            end else if (aud_dout_vld[1]) begin
               sched(1, aud_dout, m_gain[1]);
               p_ok = 1'b0;
            end else if (p_ok) begin
               sched(1, p_smp, p_gain);
               p_ok = 1'b0;
            end
            if (aud_dout_vld[0]) begin
               m_ramp++;
               if (m_ramp == R) begin
                  m_ramp = 0;
                  m_gain[0] = toward(m_gain[0], mute ? 0 : int'(gain_tgt0));
                  m_gain[1] = toward(m_gain[1], mute ? 0 : int'(gain_tgt1));
               end
            end
         end
         if (underrun_clr) m_und = 0;
      end
      cyc++;
   endtask

   function automatic void cmp(input string nm, input int unsigned act, input int unsigned exp);
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic void chk_lit(input string nm, input int unsigned act, input int unsigned exp);
      n_vec++;
      cmp(nm, act, exp);
   endfunction

   task automatic check_all();
      n_vec++;
      cmp("aud_din0", aud_din0, m_din[0]);
      cmp("aud_din1", aud_din1, m_din[1]);
      cmp("din_fresh", din_fresh, {m_fresh[1], m_fresh[0]});
      cmp("gain_cur0", gain_cur0, m_gain[0]);
      cmp("gain_cur1", gain_cur1, m_gain[1]);
      cmp("underrun_cnt", underrun_cnt, m_und);
   endtask

   task automatic step();
      model_step();
      @(negedge clk);
      check_all();
      aud_dout_vld = 2'b00; aud_din_ack = 2'b00; underrun_clr = 1'b0;
   endtask

   task automatic strobe(input logic [1:0] v, input logic [23:0] d);
      aud_dout_vld = v; aud_dout = d;
      step();
   endtask

   initial begin
      rst = 1'b1; init_done = 1'b0; mute = 1'b0; underrun_clr = 1'b0;
      aud_dout_vld = 2'b00; aud_din_ack = 2'b00; aud_dout = 24'd0;
      gain_tgt0 = 8'd0; gain_tgt1 = 8'd0; cyc = 0;
      model_reset();
      step(); step();
      chk_lit("reset_din0", aud_din0, 0);
      chk_lit("reset_fresh", din_fresh, 0);
      chk_lit("reset_gain0", gain_cur0, 0);
      chk_lit("reset_und", underrun_cnt, 0);
      rst = 1'b0; init_done = 1'b1;
      step();

      gain_tgt0 = 8'd4; gain_tgt1 = 8'd4;
      for (int k = 1; k <= 8; k++) begin
         strobe(2'b01, 24'($urandom));
         if (k % 2 == 0) chk_lit("ramp_up", gain_cur0, k / 2);
      end
      mute = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         strobe(2'b01, 24'($urandom));
         if (k % 2 == 0) chk_lit("mute_down", gain_cur0, 4 - k / 2);
      end
      mute = 1'b0; gain_tgt0 = 8'd64; gain_tgt1 = 8'd64;
      for (int k = 0; k < 140; k++) strobe(2'b01, 24'($urandom));
      chk_lit("unity_gain0", gain_cur0, 64);

      strobe(2'b01, 24'h123456); step();
      chk_lit("unity0_early", din_fresh[0] && aud_din0 == 24'h123456, 0);
      step();
      chk_lit("unity0", aud_din0, 24'h123456);
      chk_lit("unity0_fresh", din_fresh[0], 1);
      strobe(2'b10, 24'h800000); step(); step();
      chk_lit("unity1", aud_din1, 24'h800000);
      chk_lit("unity1_fresh", din_fresh[1], 1);

      strobe(2'b11, 24'h000100); step(); step();
      chk_lit("simul0", aud_din0, 24'h000100);
      chk_lit("simul1_late", aud_din1, 24'h800000);
      step();
      chk_lit("simul1", aud_din1, 24'h000100);

      aud_din_ack = 2'b01; step();
      chk_lit("ack_clear", din_fresh[0], 0);
      aud_din_ack = 2'b01; step();
      chk_lit("underrun_cnt", underrun_cnt, 1);
      chk_lit("underrun_hold", aud_din0, 24'h000100);
      underrun_clr = 1'b1; step();
      chk_lit("underrun_clr", underrun_cnt, 0);

      gain_tgt0 = 8'd255;
      for (int k = 0; k < 400; k++) strobe(2'b01, 24'($urandom));
      chk_lit("gain255", gain_cur0, 255);
      strobe(2'b01, 24'h300000); step(); step();
      chk_lit("sat_pos", aud_din0, 24'h7FFFFF);
      strobe(2'b01, 24'hD00000); step(); step();
      chk_lit("sat_neg", aud_din0, 24'h800000);
      strobe(2'b01, 24'h200000); step(); step();
      chk_lit("near_pos", aud_din0, 24'h7F8000);
      strobe(2'b01, 24'hE00000); step(); step();
      chk_lit("near_neg", aud_din0, 24'h808000);
      gain_tgt0 = 8'd1;
      for (int k = 0; k < 520; k++) strobe(2'b01, 24'($urandom));
      chk_lit("gain1", gain_cur0, 1);
      strobe(2'b01, 24'hFFFFFF); step(); step();
      chk_lit("floor_neg1", aud_din0, 24'hFFFFFF);

      strobe(2'b01, 24'h400000); strobe(2'b10, 24'h111111);
      init_done = 1'b0; step();
      chk_lit("gate_din0", aud_din0, 0);
      chk_lit("gate_din1", aud_din1, 0);
      chk_lit("gate_fresh", din_fresh, 0);
      gain_tgt0 = 8'd64;
      for (int k = 0; k < 6; k++) begin
         aud_din_ack = 2'b11;
         strobe(2'b11, 24'($urandom));
      end
      chk_lit("gate_gain_hold", gain_cur0, 1);
      chk_lit("gate_und_hold", underrun_cnt, 0);
      chk_lit("gate_fresh_hold", din_fresh, 0);
      init_done = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         if (!init_done) init_done = ($urandom_range(0, 3) == 0);
         else if ($urandom_range(0, 149) == 0) init_done = 1'b0;
         if ($urandom_range(0, 299) == 0) mute = ~mute;
         if ($urandom_range(0, 199) == 0) gain_tgt0 = 8'($urandom);
         if ($urandom_range(0, 199) == 0) gain_tgt1 = 8'($urandom);
         aud_din_ack  = {$urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3};
         underrun_clr = ($urandom_range(0, 63) == 0);
         strobe({$urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4}, 24'($urandom));
      end

      init_done = 1'b1;
      strobe(2'b11, 24'h654321);
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      chk_lit("async_rst_din0", aud_din0, 0);
      chk_lit("async_rst_fresh", din_fresh, 0);
      chk_lit("async_rst_gain1", gain_cur1, 0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 40; i++) strobe({$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1}, 24'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
